bus_request_encoder: RTL
========================

# bus_request_encoder

Sequential 8-to-3 request encoder and arbiter for the common-bus datapath. Eight bus sources raise one-hot-per-source request lines. The block picks one owner by round-robin and drives the 3-bit bus select code that the select decoder converts back to a one-hot enable. It holds the selection for the owner's whole tenure and inserts a one-cycle turnaround gap between owners.

## Interface
- MAX_TENURE, 16, maximum cycles an owner may hold the bus (legal range 1..255); used only when the timeout feature is compiled in.
- clk  in  1  single system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  8  bus request, bit i = source i; level-sensitive; the owner holds it high for its whole tenure.
- done  in  1  single-cycle release pulse from the current owner.
- sel  out  3  binary code of the current or last owner.
- sel_valid  out  1  high while sel names an active owner.
- grant  out  8  one-hot form of sel when sel_valid is high, all zeros otherwise.
- timeout  out  1  single-cycle pulse on a forced release.

## Operation
- States:
  - IDLE: no owner.
  - BUSY: owner holds the bus.
  - GAP: one-cycle turnaround.
- Reset values (async on rst_n low): state=IDLE, sel=3'd0, sel_valid=0, grant=8'h00, timeout=0, ptr=3'd0, tenure counter=0.
- IDLE, req==0: stay in IDLE; outputs unchanged.
- IDLE, req!=0: winner is the first set bit searching ptr, ptr+1, … mod 8.
  - Registered: sel=winner, sel_valid=1, ptr=winner+1 mod 8 (7 wraps to 0).
  - Next state is BUSY.
- BUSY release conditions: done==1, or req[sel]==0 (owner withdrew), or timeout expiry (see Configuration). On release:
  - Next state is GAP.
  - sel_valid=0.
  - sel keeps the last owner's code.
- Simultaneous release conditions inside BUSY produce one release only. timeout pulses only when expiry is the sole cause.
- GAP always moves to IDLE. req is ignored while in GAP.
- Requests from non-owners during BUSY are ignored; no queueing. They are served only if still asserted in IDLE.
- done asserted outside BUSY is ignored.
- grant is combinational from the registered sel and sel_valid. Exactly zero or one bit of grant is set at all times.
- Reset asserted mid-tenure drops sel_valid and grant to 0 immediately (asynchronously) and returns the block to IDLE with ptr=0.

## Timing
- Grant latency: req seen in IDLE at edge k gives sel_valid=1 after edge k, i.e. one cycle.
- Release: release condition seen at edge m gives sel_valid=0 after m. State is GAP after m and IDLE after m+1.
- Earliest next grant is after edge m+2, so the bus is idle for at least 2 cycles between owners.
- The tenure counter clears on entry to BUSY and increments on every BUSY cycle.
- timeout is registered and high for exactly the one cycle after the forcing edge.

## Configuration
- Macro: BUS_ENC_TIMEOUT_EN.
- Defined:
  - An 8-bit tenure counter is present.
  - In BUSY, when the counter equals MAX_TENURE-1 at an edge, that edge forces release and timeout=1 for the following cycle.
  - The owner therefore sees at most MAX_TENURE cycles with sel_valid=1.
- Undefined:
  - No counter exists and MAX_TENURE is unused.
  - timeout is tied to 0.
  - An owner holds the bus until done or until it drops its req.

## Test plan
- Reset and idle: rst_n low, then high with req=8'h00 for 10 cycles -> sel=0, sel_valid=0, grant=8'h00, timeout=0 throughout.
- Single requester: req=8'h20 -> one cycle later sel=3'd5, grant=8'h20. Pulse done -> sel_valid=0 next cycle. With req held, next grant to sel=5 appears 3 cycles after done.
- Round-robin with wrap: req=8'h81 held, each grant ended by done -> grant sequence 8'h01, 8'h80, 8'h01, 8'h80; ptr wraps 7->0.
- Withdrawal and ignored contenders: source 3 owns the bus, req changes 8'h08 -> 8'h06 -> release on req[3]=0, no grant during GAP, then sel=3'd1 (ptr=4 search wraps to 1).
- Timeout (macro defined, MAX_TENURE=4): req=8'h02 held, done never asserted -> sel_valid high exactly 4 cycles, timeout high one cycle, regrant after the gap. Macro undefined: sel_valid stays high for 100 cycles, timeout stays 0.
- Reset mid-tenure: during BUSY with sel=6, drive rst_n low between edges -> sel_valid, grant and sel clear immediately. After release, first grant with req=8'hFF is sel=3'd0.

Source files
------------

// File: rtl/bus_request_encoder.sv
// Round-robin 8-to-3 bus request encoder with one-cycle turnaround between owners.
// Optional tenure limit compiled in with `define BUS_ENC_TIMEOUT_EN (uses MAX_TENURE).
module bus_request_encoder #(
  parameter int MAX_TENURE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] sel,
  output logic       sel_valid,
  output logic [7:0] grant,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t     state_reg, state_next;
  logic [2:0] sel_reg, sel_next;
  logic [2:0] ptr_reg, ptr_next;
  logic       sel_valid_reg, sel_valid_next;
  logic [7:0] req_rot;
  logic [2:0] offset;
  logic [2:0] winner;
  logic       owner_req;
  logic       expire;
  logic       release_bus;

  // req_rot[j] is the request of source ptr+j, so the lowest set bit is the winner
  for (genvar gi = 0; gi < 8; gi++) begin : g_rot
    assign req_rot[gi] = req[3'(gi) + ptr_reg];
  end

  always_comb begin
    offset = 3'd0;
    for (int j = 7; j >= 0; j--) begin
      if (req_rot[j]) offset = 3'(j);
    end
  end

  assign winner      = ptr_reg + offset;
  assign owner_req   = req[sel_reg];
  assign release_bus = done | ~owner_req | expire;

`ifdef BUS_ENC_TIMEOUT_EN
  localparam logic [7:0] TENURE_LAST = 8'(MAX_TENURE - 1);

  logic [7:0] tenure_reg, tenure_next;
  logic       timeout_reg, timeout_next;

  assign expire = (tenure_reg == TENURE_LAST);

  always_comb begin
    tenure_next = 8'd0;
    if (state_reg == BUSY) tenure_next = tenure_reg + 8'd1;
  end

  // Pulse only when expiry alone forced the release
  assign timeout_next = (state_reg == BUSY) && expire && !done && owner_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tenure_reg  <= 8'd0;
      timeout_reg <= 1'b0;
    end else begin
      tenure_reg  <= tenure_next;
      timeout_reg <= timeout_next;
    end
  end

  assign timeout = timeout_reg;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    sel_valid_next = sel_valid_reg;
    ptr_next       = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next     = BUSY;
          sel_next       = winner;
          sel_valid_next = 1'b1;
          ptr_next       = winner + 3'd1;
        end
      end
      BUSY: begin
        if (release_bus) begin
          state_next     = GAP;
          sel_valid_next = 1'b0;
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sel_reg       <= 3'd0;
      sel_valid_reg <= 1'b0;
      ptr_reg       <= 3'd0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      sel_valid_reg <= sel_valid_next;
      ptr_reg       <= ptr_next;
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_grant
    assign grant[gi] = sel_valid_reg && (sel_reg == 3'(gi));
  end

  assign sel       = sel_reg;
  assign sel_valid = sel_valid_reg;

endmodule
